// File: rtl/apuf_pkg.sv
// Shared definitions for the arbiter-PUF evaluation controller:
// FSM state encoding, default parameter values and the vote threshold helper.
package apuf_pkg;

  localparam int N_STAGE_DEF     = 64;
  localparam int N_EVAL_DEF      = 15;
  localparam int SETTLE_CYC_DEF  = 8;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    FIRE   = 3'd2,
    RELAX  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Majority threshold: the voted bit is 1 when ones_cnt exceeds this value.
  function automatic logic [7:0] vote_thresh(input int n_eval);
    return 8'(n_eval / 2);
  endfunction

endpackage

// File: rtl/apuf_eval_ctrl_if.sv
// Host-side challenge/response channels of the PUF evaluation controller.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The source holds valid and its payload steady until that edge; the
// sink may raise or drop ready freely. chal_ready is 1 only while the
// controller is idle; resp_valid stays 1 with a stable payload until accepted.
interface apuf_eval_ctrl_if #(
  parameter int N_STAGE = 64
);
  logic               chal_valid;
  logic               chal_ready;
  logic [N_STAGE-1:0] chal;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_bit;
  logic [7:0]         ones_cnt;
  logic               err_timeout;

  modport master (
    output chal_valid, chal, resp_ready,
    input  chal_ready, resp_valid, resp_bit, ones_cnt, err_timeout
  );

  modport slave (
    input  chal_valid, chal, resp_ready,
    output chal_ready, resp_valid, resp_bit, ones_cnt, err_timeout
  );
endinterface

// File: rtl/apuf_vote_acc.sv
// Accumulates arbiter response bits over the evaluations of one challenge and
// forms the majority decision. Both counters saturate at N_EVAL.
module apuf_vote_acc
  import apuf_pkg::*;
#(
  parameter int N_EVAL = N_EVAL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add_en,
  input  logic       bit_in,
  output logic [7:0] ones_cnt,
  output logic [7:0] eval_cnt,
  output logic       majority
);

  logic [7:0] ones_q, ones_d;
  logic [7:0] eval_q, eval_d;

  // Next-count logic: clear on a new challenge, add one evaluation otherwise.
  always_comb begin
    ones_d = ones_q;
    eval_d = eval_q;
    if (clr) begin
      ones_d = 8'd0;
      eval_d = 8'd0;
    end else if (add_en && (eval_q < 8'(N_EVAL))) begin
      eval_d = eval_q + 8'd1;
      if (bit_in) ones_d = ones_q + 8'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= 8'd0;
      eval_q <= 8'd0;
    end else begin
      ones_q <= ones_d;
      eval_q <= eval_d;
    end
  end

  assign ones_cnt = ones_q;
  assign eval_cnt = eval_q;
  assign majority = (ones_q > vote_thresh(N_EVAL));

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: latches a challenge, launches N_EVAL
// races with settle/relax gaps, majority-votes the arbiter outputs and
// returns the result over a valid/ready channel. Purely synchronous.
module apuf_eval_ctrl
  import apuf_pkg::*;
#(
  parameter int N_STAGE     = N_STAGE_DEF,
  parameter int N_EVAL      = N_EVAL_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  apuf_eval_ctrl_if.slave    host,
  output logic [N_STAGE-1:0] cT,
  output logic [N_STAGE-1:0] cB,
  output logic               tigSignal,
  input  logic               respReady,
  input  logic               respBit,
  output state_t             state_dbg
);

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [15:0]        settle_cnt_q, settle_cnt_d;
  logic [15:0]        fire_cnt_q, fire_cnt_d;
  logic [N_STAGE-1:0] chal_q, chal_d;
  logic               err_q, err_d;
  logic               tig_q, tig_d;
  logic               acc_clr, acc_add;
  logic [7:0]         ones_cnt, eval_cnt;
  logic               majority;

  apuf_vote_acc #(.N_EVAL(N_EVAL)) u_vote (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .add_en   (acc_add),
    .bit_in   (respBit),
    .ones_cnt (ones_cnt),
    .eval_cnt (eval_cnt),
    .majority (majority)
  );

  // Next-state, counters and capture control.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    fire_cnt_d   = fire_cnt_q;
    chal_d       = chal_q;
    err_d        = err_q;
    acc_clr      = 1'b0;
    acc_add      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host.chal_valid) begin
          chal_d       = host.chal;
          err_d        = 1'b0;
          acc_clr      = 1'b1;
          settle_cnt_d = 16'd0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = 16'd0;
          fire_cnt_d   = 16'd0;
          state_d      = FIRE;
        end else begin
          settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end
      FIRE: begin
        // A response arriving in the last allowed cycle still counts.
        if (respReady) begin
          acc_add      = 1'b1;
          settle_cnt_d = 16'd0;
          state_d      = RELAX;
        end else if (fire_cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          fire_cnt_d = fire_cnt_q + 16'd1;
        end
      end
      RELAX: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = 16'd0;
          if (eval_cnt < 8'(N_EVAL)) begin
            fire_cnt_d = 16'd0;
            state_d    = FIRE;
          end else begin
            state_d = DONE;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end
      DONE: begin
        if (host.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Launch line is a flop that is high exactly while the FSM sits in FIRE.
    tig_d = (state_d == FIRE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= 16'd0;
      fire_cnt_q   <= 16'd0;
      chal_q       <= '0;
      err_q        <= 1'b0;
      tig_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      fire_cnt_q   <= fire_cnt_d;
      chal_q       <= chal_d;
      err_q        <= err_d;
      tig_q        <= tig_d;
    end
  end

  assign cT               = chal_q;
  assign cB               = chal_q;
  assign tigSignal        = tig_q;
  assign state_dbg        = state_q;
  assign host.chal_ready  = (state_q == IDLE);
  assign host.resp_valid  = (state_q == DONE);
  assign host.resp_bit    = (state_q == DONE) && !err_q && majority;
  assign host.ones_cnt    = ones_cnt;
  assign host.err_timeout = err_q;

endmodule

// File: doc/apuf_eval_ctrl.md
APUF_EVAL_CTRL -- requirements
Module: apuf_eval_ctrl

Interface
REQ-001 SHALL have parameter N_STAGE, default 64: challenge width, i.e. arbiter stages.
REQ-002 SHALL have parameter N_EVAL, default 15 (odd, 1..255): evaluations per challenge for majority vote.
REQ-003 SHALL have parameter SETTLE_CYC, default 8 (>=1): cycles challenge is held stable before launch, and cycles tigSignal is held low after each evaluation.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255 (>=1): maximum cycles waited for respReady per evaluation.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 chal_valid  in  1  challenge request valid.
REQ-008 chal_ready  out  1  controller idle and able to accept a challenge.
REQ-009 chal  in  N_STAGE  challenge value.
REQ-010 cT  out  N_STAGE  upper-path challenge to the PUF.
REQ-011 cB  out  N_STAGE  lower-path challenge to the PUF.
REQ-012 tigSignal  out  1  race launch signal to the PUF.
REQ-013 respReady  in  1  PUF arbiter has resolved.
REQ-014 respBit  in  1  PUF arbiter output, valid while respReady=1.
REQ-015 resp_valid  out  1  voted result available.
REQ-016 resp_ready  in  1  consumer accepts result.
REQ-017 resp_bit  out  1  majority-voted response.
REQ-018 ones_cnt  out  8  count of respBit=1 over the completed evaluations.
REQ-019 err_timeout  out  1  result aborted by timeout; qualified by resp_valid.

Function
REQ-020 States: IDLE, SETTLE, FIRE, RELAX, DONE.
REQ-021 IDLE: chal_ready=1; on chal_valid=1 latch chal into cT and cB (identical), clear ones_cnt, eval counter and err_timeout, go to SETTLE.
REQ-022 cT/cB SHALL stay constant from capture until the next capture.
REQ-023 SETTLE: tigSignal=0 for exactly SETTLE_CYC cycles, then FIRE.
REQ-024 FIRE: tigSignal=1 (registered); on the first cycle with respReady=1 sample respBit, add it to ones_cnt, increment eval counter, go to RELAX.
REQ-025 FIRE: if TIMEOUT_CYC cycles elapse without respReady, set err_timeout=1 and go to DONE (no further evaluations).
REQ-026 RELAX: tigSignal=0 for SETTLE_CYC cycles; then FIRE if eval counter < N_EVAL, else DONE.
REQ-027 DONE: resp_valid=1, resp_bit=(ones_cnt > N_EVAL/2), outputs stable until resp_ready=1; handshake cycle returns to IDLE.
REQ-028 On timeout, resp_bit SHALL be 0 and ones_cnt holds the partial count.
REQ-029 chal_ready SHALL be 0 in every state except IDLE; chal_valid outside IDLE is ignored.
REQ-030 respReady outside FIRE SHALL be ignored.
REQ-031 Latency without timeout: capture to resp_valid = SETTLE_CYC + sum over evals of (fire cycles + SETTLE_CYC) + 1.
REQ-032 ones_cnt SHALL never exceed N_EVAL; counters SHALL not wrap.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, tigSignal=0, cT=cB=0, resp_valid=0, resp_bit=0, ones_cnt=0, err_timeout=0, all counters 0.
REQ-034 Reset mid-operation SHALL discard the evaluation; no resp_valid is produced.
REQ-035 chal_ready SHALL be 1 on the first clock after rst_n deasserts.

Structure
REQ-036 State encoding and default parameter constants SHALL reside in shared package apuf_pkg.
REQ-037 PUF instance SHALL be external; controller contains no delay elements, only synchronous logic.
REQ-038 One sub-module natural: apuf_vote_acc (bit accumulator plus majority compare).

Verification
REQ-039 N_EVAL=15, PUF model returns 1 on 9 evaluations -> ones_cnt=9, resp_bit=1, err_timeout=0.
REQ-040 PUF returns 1 on 7 of 15 -> ones_cnt=7, resp_bit=0.
REQ-041 respReady never asserts, TIMEOUT_CYC=255 -> after 255 FIRE cycles resp_valid=1, err_timeout=1, resp_bit=0, ones_cnt=0.
REQ-042 resp_ready held 0 for 20 cycles in DONE -> resp_valid, resp_bit, ones_cnt stable; new chal_valid ignored; chal_ready=0.
REQ-043 rst_n pulsed low during third FIRE -> tigSignal=0 immediately, cT=cB=0, no resp_valid, chal_ready=1 after release.
REQ-044 respReady after 3 cycles each eval, SETTLE_CYC=8, N_EVAL=1 -> resp_valid exactly 8+3+8+1=20 cycles after capture; tigSignal low throughout SETTLE and RELAX.
